// File: rtl/led_blink_gen_pkg.sv
// Shared types and width helpers for the LED blink generator and its ms tick source.
package led_blink_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } blink_state_e;

    // $clog2 that never returns zero, so a counter of range n always has at least one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler; restart re-phases it so the first tick lands clk_freq cycles later.
module ms_tick_gen
    import led_blink_gen_pkg::*;
#(
    parameter int clk_freq = 95000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = width_of(clk_freq);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clk_freq - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign tick = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (restart || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_blink_gen.sv
// Turns single-cycle event strobes into fixed-length LED blinks, queueing events that arrive mid-blink.
module led_blink_gen
    import led_blink_gen_pkg::*;
#(
    parameter int clk_freq    = 95000,
    parameter int on_ms       = 100,
    parameter int off_ms      = 100,
    parameter int max_pending = 15
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                event_in,
    input  logic                                clr,
    output logic                                led_out,
    output logic                                busy,
    output logic [width_of(max_pending+1)-1:0]  pending,
    output logic                                overflow
);

    localparam int PEND_W = width_of(max_pending + 1);
    localparam int MS_W   = width_of(((on_ms > off_ms) ? on_ms : off_ms) + 1);
    localparam logic [MS_W-1:0]   ON_LAST  = MS_W'(on_ms - 1);
    localparam logic [MS_W-1:0]   OFF_LAST = MS_W'(off_ms - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(max_pending);

    blink_state_e      state_reg;
    logic [MS_W-1:0]   ms_cnt_reg;
    logic [PEND_W-1:0] pending_reg;
    logic              led_reg;
    logic              busy_reg;
    logic              overflow_reg;

    logic tick;
    logic restart;
    logic on_done;
    logic off_done;
    logic have_pending;
    logic accept;
    logic consume;

    // The prescaler is held at zero while idle and re-phased on every state change,
    // so each ON/OFF interval is an exact number of clock cycles.
    always_comb begin
        have_pending = (pending_reg != '0);
        on_done      = (state_reg == ST_ON)  && tick && (ms_cnt_reg == ON_LAST);
        off_done     = (state_reg == ST_OFF) && tick && (ms_cnt_reg == OFF_LAST);
        accept       = event_in && !clr;
        consume      = !clr && have_pending && ((state_reg == ST_IDLE) || off_done);
        restart      = clr || (state_reg == ST_IDLE) || on_done || off_done;
    end

    ms_tick_gen #(
        .clk_freq (clk_freq)
    ) u_ms_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            ms_cnt_reg <= '0;
            led_reg    <= 1'b0;
            busy_reg   <= 1'b0;
        end else if (clr) begin
            state_reg  <= ST_IDLE;
            ms_cnt_reg <= '0;
            led_reg    <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    ms_cnt_reg <= '0;
                    if (have_pending) begin
                        state_reg <= ST_ON;
                        led_reg   <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (on_done) begin
                        state_reg  <= ST_OFF;
                        ms_cnt_reg <= '0;
                        led_reg    <= 1'b0;
                    end else if (tick) begin
                        ms_cnt_reg <= ms_cnt_reg + MS_W'(1);
                    end
                end
                ST_OFF: begin
                    if (off_done) begin
                        ms_cnt_reg <= '0;
                        if (have_pending) begin
                            state_reg <= ST_ON;
                            led_reg   <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else if (tick) begin
                        ms_cnt_reg <= ms_cnt_reg + MS_W'(1);
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    ms_cnt_reg <= '0;
                    led_reg    <= 1'b0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    // A simultaneous event and consume cancel out, so saturation only matters for a bare event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= 1'b0;
            if (clr) begin
                pending_reg <= '0;
            end else if (accept && !consume) begin
                if (pending_reg == PEND_MAX) begin
                    overflow_reg <= 1'b1;
                end else begin
                    pending_reg <= pending_reg + PEND_W'(1);
                end
            end else if (consume && !accept) begin
                pending_reg <= pending_reg - PEND_W'(1);
            end
        end
    end

    assign led_out  = led_reg;
    assign busy     = busy_reg;
    assign pending  = pending_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_led_blink_gen.sv
// Scenario bench for led_blink_gen with a 4-cycle ms, 2 ms on, 1 ms off, queue depth 3.
module tb_led_blink_gen;

    logic       clk;
    logic       rst;
    logic       event_in;
    logic       clr;
    logic       led_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int vectors;
    int miscompares;

    // One entry per clock: inputs for the edge and the expected {led,busy,pending,overflow} after it.
    typedef struct {
        logic       ev;
        logic       cl;
        logic [4:0] exp;
    } vec_t;

    vec_t sb[$];

    led_blink_gen #(
        .clk_freq    (4),
        .on_ms       (2),
        .off_ms      (1),
        .max_pending (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .event_in (event_in),
        .clr      (clr),
        .led_out  (led_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input int n, input logic ev, input logic cl, input logic led,
                       input logic bsy, input logic [1:0] pd, input logic ov);
        vec_t v;
        v.ev  = ev;
        v.cl  = cl;
        v.exp = {led, bsy, pd, ov};
        repeat (n) sb.push_back(v);
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst = 1'b0; event_in = 1'b0; clr = 1'b0;
        @(posedge clk); #1;
        got = {led_out, busy, pending, overflow};
        vectors++;
        if (got !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_state: got %b want %b", got, 5'b0);
        end
        @(negedge clk) rst = 1'b1;
        add(3, 0, 0, 0, 0, 2'd0, 0);
        for (int n = 0; sb.size() > 0; n++) begin
            vec_t v = sb.pop_front();
            event_in = v.ev; clr = v.cl;
            @(posedge clk); #1;
            got = {led_out, busy, pending, overflow};
            vectors++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d: got %b want %b", n, got, v.exp);
            end
        end
        $display("test_reset: checked idle after release");
    endtask

    task automatic test_single();
        logic [4:0] got;
        add(1, 1, 0, 0, 0, 2'd1, 0);
        add(8, 0, 0, 1, 1, 2'd0, 0);
        add(4, 0, 0, 0, 1, 2'd0, 0);
        add(2, 0, 0, 0, 0, 2'd0, 0);
        for (int n = 0; sb.size() > 0; n++) begin
            vec_t v = sb.pop_front();
            event_in = v.ev; clr = v.cl;
            @(posedge clk); #1;
            got = {led_out, busy, pending, overflow};
            vectors++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL single cyc %0d: got %b want %b", n, got, v.exp);
            end
        end
        event_in = 1'b0;
        $display("test_single: one blink 8 on / 4 off");
    endtask

    task automatic test_back_to_back();
        logic [4:0] got;
        add(1, 1, 0, 0, 0, 2'd1, 0);
        add(1, 1, 0, 1, 1, 2'd1, 0);
        add(1, 1, 0, 1, 1, 2'd2, 0);
        add(6, 0, 0, 1, 1, 2'd2, 0);
        add(4, 0, 0, 0, 1, 2'd2, 0);
        add(8, 0, 0, 1, 1, 2'd1, 0);
        add(4, 0, 0, 0, 1, 2'd1, 0);
        add(8, 0, 0, 1, 1, 2'd0, 0);
        add(4, 0, 0, 0, 1, 2'd0, 0);
        add(2, 0, 0, 0, 0, 2'd0, 0);
        for (int n = 0; sb.size() > 0; n++) begin
            vec_t v = sb.pop_front();
            event_in = v.ev; clr = v.cl;
            @(posedge clk); #1;
            got = {led_out, busy, pending, overflow};
            vectors++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL back_to_back cyc %0d: got %b want %b", n, got, v.exp);
            end
        end
        event_in = 1'b0;
        $display("test_back_to_back: three queued blinks");
    endtask

    task automatic test_overflow();
        logic [4:0] got;
        add(1, 1, 0, 0, 0, 2'd1, 0);
        add(1, 1, 0, 1, 1, 2'd1, 0);
        add(1, 1, 0, 1, 1, 2'd2, 0);
        add(1, 1, 0, 1, 1, 2'd3, 0);
        add(1, 1, 0, 1, 1, 2'd3, 1);
        add(4, 0, 0, 1, 1, 2'd3, 0);
        add(4, 0, 0, 0, 1, 2'd3, 0);
        add(8, 0, 0, 1, 1, 2'd2, 0);
        add(4, 0, 0, 0, 1, 2'd2, 0);
        add(8, 0, 0, 1, 1, 2'd1, 0);
        add(4, 0, 0, 0, 1, 2'd1, 0);
        add(8, 0, 0, 1, 1, 2'd0, 0);
        add(4, 0, 0, 0, 1, 2'd0, 0);
        add(2, 0, 0, 0, 0, 2'd0, 0);
        for (int n = 0; sb.size() > 0; n++) begin
            vec_t v = sb.pop_front();
            event_in = v.ev; clr = v.cl;
            @(posedge clk); #1;
            got = {led_out, busy, pending, overflow};
            vectors++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL overflow cyc %0d: got %b want %b", n, got, v.exp);
            end
        end
        event_in = 1'b0;
        $display("test_overflow: five strobes, four blinks, one drop");
    endtask

    task automatic test_event_during_on();
        logic [4:0] got;
        add(1, 1, 0, 0, 0, 2'd1, 0);
        add(2, 0, 0, 1, 1, 2'd0, 0);
        add(1, 1, 0, 1, 1, 2'd1, 0);
        add(5, 0, 0, 1, 1, 2'd1, 0);
        add(4, 0, 0, 0, 1, 2'd1, 0);
        add(8, 0, 0, 1, 1, 2'd0, 0);
        add(4, 0, 0, 0, 1, 2'd0, 0);
        add(2, 0, 0, 0, 0, 2'd0, 0);
        for (int n = 0; sb.size() > 0; n++) begin
            vec_t v = sb.pop_front();
            event_in = v.ev; clr = v.cl;
            @(posedge clk); #1;
            got = {led_out, busy, pending, overflow};
            vectors++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL event_during_on cyc %0d: got %b want %b", n, got, v.exp);
            end
        end
        event_in = 1'b0;
        $display("test_event_during_on: OFF goes straight to ON");
    endtask

    task automatic test_clr();
        logic [4:0] got;
        add(1, 1, 0, 0, 0, 2'd1, 0);
        add(1, 1, 0, 1, 1, 2'd1, 0);
        add(1, 1, 0, 1, 1, 2'd2, 0);
        add(1, 0, 0, 1, 1, 2'd2, 0);
        add(1, 1, 1, 0, 0, 2'd0, 0);
        add(14, 0, 0, 0, 0, 2'd0, 0);
        for (int n = 0; sb.size() > 0; n++) begin
            vec_t v = sb.pop_front();
            event_in = v.ev; clr = v.cl;
            @(posedge clk); #1;
            got = {led_out, busy, pending, overflow};
            vectors++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL clr cyc %0d: got %b want %b", n, got, v.exp);
            end
        end
        event_in = 1'b0; clr = 1'b0;
        $display("test_clr: flush mid-blink with queued events");
    endtask

    task automatic test_reset_mid_on();
        logic [4:0] got;
        add(1, 1, 0, 0, 0, 2'd1, 0);
        add(1, 1, 0, 1, 1, 2'd1, 0);
        add(2, 0, 0, 1, 1, 2'd1, 0);
        for (int n = 0; sb.size() > 0; n++) begin
            vec_t v = sb.pop_front();
            event_in = v.ev; clr = v.cl;
            @(posedge clk); #1;
            got = {led_out, busy, pending, overflow};
            vectors++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL reset_mid_on pre cyc %0d: got %b want %b", n, got, v.exp);
            end
        end
        event_in = 1'b0;
        #2 rst = 1'b0;
        #1;
        got = {led_out, busy, pending, overflow};
        vectors++;
        if (got !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_mid_on async: got %b want %b", got, 5'b0);
        end
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        add(14, 0, 0, 0, 0, 2'd0, 0);
        for (int n = 0; sb.size() > 0; n++) begin
            vec_t v = sb.pop_front();
            event_in = v.ev; clr = v.cl;
            @(posedge clk); #1;
            got = {led_out, busy, pending, overflow};
            vectors++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL reset_mid_on post cyc %0d: got %b want %b", n, got, v.exp);
            end
        end
        $display("test_reset_mid_on: async drop, no resume");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        event_in    = 1'b0;
        clr         = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_event_during_on();
        test_clr();
        test_reset_mid_on();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
